cash_dispense_sequencer: RTL and testbench

//  Sequences the bill dispenser after the ATM controller asserts entregarDinero.

---
 rtl/cash_dispense_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_cash_dispense_sequencer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cash_dispense_sequencer.sv
// Bill dispenser sequencer: greedy payout planning over four cassettes, then
// one-bill-at-a-time delivery to the mechanism through a req/ack handshake.
module cash_dispense_sequencer #(
    parameter int MONTO_W = 32,
    parameter int CNT_W   = 10,
    parameter int DEN0    = 20000,
    parameter int DEN1    = 10000,
    parameter int DEN2    = 5000,
    parameter int DEN3    = 1000,
    parameter int TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 entregarDinero,
    input  logic [MONTO_W-1:0]   monto,
    input  logic                 cargaSTB,
    input  logic [4*CNT_W-1:0]   cargaCant,
    input  logic                 dispAck,
    output logic                 dispSTB,
    output logic [1:0]           dispSel,
    output logic                 ocupado,
    output logic                 listo,
    output logic                 falla,
    output logic [1:0]           codigoFalla,
    output logic [MONTO_W-1:0]   montoEntregado,
    output logic [4*CNT_W-1:0]   conteoCassettes
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PLAN,
        S_DISPENSE,
        S_DONE,
        S_FAIL
    } state_t;

    state_t state, next_state;

    logic [3:0][CNT_W-1:0] count;
    logic [3:0][CNT_W-1:0] shadow;
    logic [3:0][CNT_W-1:0] plan;
    logic [MONTO_W-1:0]    rem;
    logic [MONTO_W-1:0]    delivered;
    logic [1:0]            code;
    logic                  stb;
    logic [1:0]            sel;
    logic [WD_W-1:0]       wd;

    logic       pick_ok;
    logic [1:0] pick;
    logic       serve_ok;
    logic [1:0] serve;
    logic       timeout_hit;

    function automatic logic [MONTO_W-1:0] den(input logic [1:0] idx);
        case (idx)
            2'd0:    den = MONTO_W'(DEN0);
            2'd1:    den = MONTO_W'(DEN1);
            2'd2:    den = MONTO_W'(DEN2);
            default: den = MONTO_W'(DEN3);
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        pick_ok  = 1'b0;
        pick     = 2'd0;
        serve_ok = 1'b0;
        serve    = 2'd0;
        // Descending scan so the lowest qualifying cassette wins.
        for (int i = 3; i >= 0; i--) begin
            if (rem >= den(2'(i)) && shadow[2'(i)] != '0) begin
                pick_ok = 1'b1;
                pick    = 2'(i);
            end
            if (plan[2'(i)] != '0) begin
                serve_ok = 1'b1;
                serve    = 2'(i);
            end
        end
        timeout_hit = stb && !dispAck && (wd == WD_W'(TIMEOUT - 1));
        next_state  = state;
        case (state)
            S_IDLE:     if (entregarDinero) next_state = S_PLAN;
            S_PLAN: begin
                if (rem == '0)    next_state = S_DISPENSE;
                else if (!pick_ok) next_state = S_FAIL;
            end
            S_DISPENSE: begin
                if (stb) begin
                    if (timeout_hit) next_state = S_FAIL;
                end else if (!serve_ok) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:     next_state = S_IDLE;
            S_FAIL:     next_state = S_IDLE;
            default:    next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            shadow    <= '0;
            plan      <= '0;
            rem       <= '0;
            delivered <= '0;
            code      <= 2'b00;
            stb       <= 1'b0;
            sel       <= 2'd0;
            wd        <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cargaSTB) count <= cargaCant;
                    if (entregarDinero) begin
                        rem       <= monto;
                        delivered <= '0;
                        code      <= 2'b00;
                        plan      <= '0;
                        // A simultaneous reload is visible to the plan.
                        shadow    <= cargaSTB ? cargaCant : count;
                    end
                end
                S_PLAN: begin
                    if (rem != '0) begin
                        if (pick_ok) begin
                            rem          <= rem - den(pick);
                            plan[pick]   <= plan[pick] + 1'b1;
                            shadow[pick] <= shadow[pick] - 1'b1;
                        end else begin
                            code <= 2'b01;
                        end
                    end
                end
                S_DISPENSE: begin
                    if (stb) begin
                        if (dispAck) begin
                            // Strobe drops for at least one cycle between bills.
                            stb       <= 1'b0;
                            wd        <= '0;
                            delivered <= delivered + den(sel);
                            if (plan[sel] != '0)  plan[sel]  <= plan[sel] - 1'b1;
                            if (count[sel] != '0) count[sel] <= count[sel] - 1'b1;
                        end else if (timeout_hit) begin
                            stb  <= 1'b0;
                            wd   <= '0;
                            code <= 2'b10;
                        end else begin
                            wd <= wd + 1'b1;
                        end
                    end else if (serve_ok) begin
                        stb <= 1'b1;
                        sel <= serve;
                        wd  <= '0;
                    end
                end
                default: begin
                    stb <= 1'b0;
                    wd  <= '0;
                end
            endcase
        end
    end

    assign dispSTB         = stb;
    assign dispSel         = sel;
    assign ocupado         = (state != S_IDLE);
    assign listo           = (state == S_DONE);
    assign falla           = (state == S_FAIL);
    assign codigoFalla     = code;
    assign montoEntregado  = delivered;
    assign conteoCassettes = count;

endmodule

// File: tb/tb_cash_dispense_sequencer.sv
// Scoreboard bench for cash_dispense_sequencer: a greedy payout model queues the
// expected bill requests and completions; a monitor pops them as the DUT presents them.
module tb_cash_dispense_sequencer;

    localparam int MONTO_W = 32;
    localparam int CNT_W   = 10;
    localparam int TIMEOUT = 16;
    localparam int CW      = 4 * CNT_W;

    logic                clk;
    logic                rst;
    logic                entregarDinero;
    logic [MONTO_W-1:0]  monto;
    logic                cargaSTB;
    logic [CW-1:0]       cargaCant;
    logic                dispAck;
    logic                dispSTB;
    logic [1:0]          dispSel;
    logic                ocupado;
    logic                listo;
    logic                falla;
    logic [1:0]          codigoFalla;
    logic [MONTO_W-1:0]  montoEntregado;
    logic [CW-1:0]       conteoCassettes;

    cash_dispense_sequencer #(
        .MONTO_W(MONTO_W), .CNT_W(CNT_W), .DEN0(20000), .DEN1(10000),
        .DEN2(5000), .DEN3(1000), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .entregarDinero(entregarDinero), .monto(monto),
        .cargaSTB(cargaSTB), .cargaCant(cargaCant), .dispAck(dispAck),
        .dispSTB(dispSTB), .dispSel(dispSel), .ocupado(ocupado), .listo(listo),
        .falla(falla), .codigoFalla(codigoFalla), .montoEntregado(montoEntregado),
        .conteoCassettes(conteoCassettes)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // kind: 0 = bill request, 1 = listo, 2 = falla
    typedef struct {
        int            kind;
        int            sel;
        int            code;
        longint        amt;
        logic [CW-1:0] cnts;
    } ev_t;

    ev_t    exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     model_cnt[4];
    longint den[4] = '{20000, 10000, 5000, 1000};

    int bill_no      = 0;
    int withhold_idx = -1;
    int wait_c       = 0;
    bit ack_en       = 1'b1;
    int stb_run      = 0;
    bit prev_stb     = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] pack_cnt();
        logic [CW-1:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) r[i*CNT_W +: CNT_W] = CNT_W'(model_cnt[i]);
        return r;
    endfunction

    task automatic pop_and_check(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            check("unexpected_output_kind", 64'(kind), 64'd99);
            return;
        end
        e = exp_q.pop_front();
        check("event_kind", 64'(kind), 64'(e.kind));
        if (kind == 0) begin
            check("disp_sel", 64'(dispSel), 64'(e.sel));
        end else begin
            check("codigo_falla", 64'(codigoFalla), 64'(e.code));
            check("monto_entregado", 64'(montoEntregado), 64'(e.amt));
            check("conteo_cassettes", 64'(conteoCassettes), 64'(e.cnts));
            if (kind == 2 && e.code == 2) check("timeout_len", 64'(stb_run), 64'(TIMEOUT));
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (dispSTB && !prev_stb) begin
                    stb_run = 1;
                    pop_and_check(0);
                end else if (dispSTB) begin
                    stb_run++;
                end
                if (listo) pop_and_check(1);
                if (falla) pop_and_check(2);
            end else begin
                stb_run = 0;
            end
            prev_stb = dispSTB;
        end
    end

    // Mechanism responder: acks each request after 0..3 cycles unless withheld
    initial begin
        dispAck = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                dispAck = 1'b0;
                wait_c  = 0;
            end else if (dispAck) begin
                dispAck = 1'b0;
                bill_no++;
                wait_c  = $urandom_range(0, 3);
            end else if (dispSTB && ack_en && bill_no != withhold_idx) begin
                if (wait_c == 0) dispAck = 1'b1;
                else wait_c--;
            end
        end
    end

    task automatic load(input int c0, input int c1, input int c2, input int c3);
        @(negedge clk);
        cargaSTB  = 1'b1;
        cargaCant = {CNT_W'(c3), CNT_W'(c2), CNT_W'(c1), CNT_W'(c0)};
        model_cnt[0] = c0; model_cnt[1] = c1; model_cnt[2] = c2; model_cnt[3] = c3;
        @(negedge clk);
        cargaSTB = 1'b0;
    endtask

    // Reference: greedy count per denomination via division, then expected events.
    task automatic predict(input longint amt, input int withhold);
        longint rem;
        longint delivered;
        int     n[4];
        int     k;
        bit     stop;
        ev_t    e;
        rem = amt;
        for (int i = 0; i < 4; i++) begin
            n[i] = int'(rem / den[i]);
            if (n[i] > model_cnt[i]) n[i] = model_cnt[i];
            rem = rem - longint'(n[i]) * den[i];
        end
        if (rem != 0) begin
            e = '{kind: 2, sel: 0, code: 1, amt: 0, cnts: pack_cnt()};
            exp_q.push_back(e);
            return;
        end
        delivered = 0;
        k = 0;
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < n[i]; j++) begin
                if (!stop) begin
                    e = '{kind: 0, sel: i, code: 0, amt: 0, cnts: '0};
                    exp_q.push_back(e);
                    if (k == withhold) begin
                        e = '{kind: 2, sel: 0, code: 2, amt: delivered, cnts: pack_cnt()};
                        exp_q.push_back(e);
                        stop = 1'b1;
                    end else begin
                        model_cnt[i]--;
                        delivered += den[i];
                        k++;
                    end
                end
            end
        end
        if (!stop) begin
            e = '{kind: 1, sel: 0, code: 0, amt: delivered, cnts: pack_cnt()};
            exp_q.push_back(e);
        end
    endtask

    task automatic run_op(input longint amt, input int withhold, input bit inject);
        bit done;
        done = 1'b0;
        predict(amt, withhold);
        bill_no      = 0;
        withhold_idx = withhold;
        ack_en       = 1'b1;
        @(negedge clk);
        entregarDinero = 1'b1;
        monto          = MONTO_W'(amt);
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            entregarDinero = 1'b0;
            cargaSTB       = 1'b0;
            if (inject && c == 1 && ocupado) begin
                entregarDinero = 1'b1;
                cargaSTB       = 1'b1;
                monto          = $urandom;
                cargaCant      = {$urandom, $urandom};
            end
            if (c > 0 && exp_q.size() == 0 && !ocupado) begin
                done = 1'b1;
                break;
            end
        end
        entregarDinero = 1'b0;
        cargaSTB       = 1'b0;
        if (!done) begin
            check("op_completion_bound", 64'd0, 64'd1);
            exp_q.delete();
        end
    endtask

    initial begin
        rst            = 1'b1;
        entregarDinero = 1'b0;
        monto          = '0;
        cargaSTB       = 1'b0;
        cargaCant      = '0;
        for (int i = 0; i < 4; i++) model_cnt[i] = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ctrl_outputs",
              64'({dispSTB, dispSel, ocupado, listo, falla, codigoFalla}), 64'd0);
        check("reset_monto_entregado", 64'(montoEntregado), 64'd0);
        check("reset_conteo", 64'(conteoCassettes), 64'd0);

        // Mixed denominations, one bill from each cassette and two of the smallest
        load(5, 5, 5, 5);
        run_op(37000, -1, 1'b0);
        check("t1_conteo", 64'(conteoCassettes),
              64'({10'd3, 10'd4, 10'd4, 10'd4}));
        check("t1_monto", 64'(montoEntregado), 64'd37000);

        // Not payable
        load(5, 5, 5, 5);
        run_op(1500, -1, 1'b0);
        check("t2_codigo", 64'(codigoFalla), 64'd1);
        check("t2_conteo", 64'(conteoCassettes),
              64'({10'd5, 10'd5, 10'd5, 10'd5}));

        // Greedy spills into the next cassette when one runs empty
        load(1, 2, 0, 0);
        run_op(40000, -1, 1'b0);
        check("t3_conteo", 64'(conteoCassettes), 64'd0);

        // Mechanism timeout on the second bill
        load(5, 5, 5, 5);
        run_op(30000, 1, 1'b0);
        check("t4_codigo", 64'(codigoFalla), 64'd2);
        check("t4_monto", 64'(montoEntregado), 64'd20000);
        check("t4_c0", 64'(conteoCassettes[CNT_W-1:0]), 64'd4);

        // Reset in the middle of dispensing
        load(5, 5, 5, 5);
        exp_q.push_back('{kind: 0, sel: 0, code: 0, amt: 0, cnts: '0});
        ack_en       = 1'b0;
        bill_no      = 0;
        withhold_idx = -1;
        @(negedge clk);
        entregarDinero = 1'b1;
        monto          = 32'd20000;
        @(negedge clk);
        entregarDinero = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (dispSTB) break;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_disp_stb", 64'(dispSTB), 64'd0);
        check("t5_ocupado", 64'(ocupado), 64'd0);
        check("t5_no_pulse", 64'({listo, falla}), 64'd0);
        check("t5_conteo", 64'(conteoCassettes), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) model_cnt[i] = 0;
        check("t5_bill_seen", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        ack_en = 1'b1;
        load(2, 0, 0, 0);
        run_op(20000, -1, 1'b0);
        check("t5_restart_monto", 64'(montoEntregado), 64'd20000);

        // Strobes while busy are ignored; zero amount completes with no bill
        load(5, 5, 5, 5);
        run_op(36000, -1, 1'b1);
        run_op(0, -1, 1'b1);
        check("t6_zero_monto", 64'(montoEntregado), 64'd0);

        // Randomized operations
        for (int n = 0; n < 30; n++) begin
            longint amt;
            int     wh;
            if ($urandom_range(0, 2) == 0)
                load($urandom_range(0, 7), $urandom_range(0, 7),
                     $urandom_range(0, 7), $urandom_range(0, 7));
            amt = longint'($urandom_range(0, 120)) * 1000;
            if ($urandom_range(0, 7) == 0) amt += 500;
            wh = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 3)) : -1;
            run_op(amt, wh, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
